// File: rtl/serial_word_rx.sv
// Serial word receiver: synchronises data_in/com_en, frames WIDTH-bit words,
// filters idle words and buffers the rest in a small FIFO with a valid/ready drain.
module serial_word_rx #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1,
    parameter int FILTER_IDLE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       com_en,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           last_word,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       overflow,
    output logic                       frame_err,
    input  logic                       clr_flags
);

    // state | meaning
    // IDLE  | waiting for s_en to rise; first bit of a frame
    // SHIFT | collecting bits 1..WIDTH-1 of the current frame
    // DRAIN | word complete (or post-reset); ignore bits until s_en falls
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [SYNC_STAGES-1:0] din_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic                   s_din;
    logic                   s_en;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [WIDTH-1:0]       sr, sr_n, sr_shift;
    logic                   commit, commit_n;
    logic                   ferr_set;

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr, rd_next;
    logic [FW-1:0]          fill_n, fill_after_pop;
    logic [WIDTH-1:0]       head_n;
    logic                   pop, push, accept, room, is_idle, ovf_set;

    // com_en flops reset high so a link held enabled through reset looks mid-frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            din_sync <= '0;
            en_sync  <= '1;
        end else begin
            din_sync[0] <= data_in;
            en_sync[0]  <= com_en;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                din_sync[i] <= din_sync[i-1];
                en_sync[i]  <= en_sync[i-1];
            end
        end
    end

    assign s_din = din_sync[SYNC_STAGES-1];
    assign s_en  = en_sync[SYNC_STAGES-1];

    always_comb begin
        if (MSB_FIRST != 0) sr_shift = {sr[WIDTH-2:0], s_din};
        else                sr_shift = {s_din, sr[WIDTH-1:1]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= DRAIN;
            cnt    <= '0;
            sr     <= '0;
            commit <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sr     <= sr_n;
            commit <= commit_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sr_n     = sr;
        commit_n = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE: begin
                if (s_en) begin
                    sr_n    = sr_shift;
                    cnt_n   = CW'(1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (s_en) begin
                    sr_n  = sr_shift;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        commit_n = 1'b1;
                        state_n  = DRAIN;
                    end
                end else begin
                    ferr_set = 1'b1;
                    sr_n     = '0;
                    state_n  = IDLE;
                end
            end
            DRAIN: begin
                if (!s_en) state_n = IDLE;
            end
            default: state_n = DRAIN;
        endcase
    end

    // sr holds the complete word during the commit cycle; the FSM is in DRAIN then
    always_comb begin
        pop            = out_valid & out_ready;
        is_idle        = (FILTER_IDLE != 0) && (sr == '1);
        accept         = commit && !is_idle;
        room           = (fill != FW'(DEPTH));
        push           = accept && (room || pop);
        ovf_set        = accept && !room && !pop;
        fill_after_pop = pop ? fill - FW'(1) : fill;
        fill_n         = push ? fill_after_pop + FW'(1) : fill_after_pop;
        rd_next        = pop ? rd_ptr + AW'(1) : rd_ptr;
        if (fill_n == '0)
            head_n = '0;
        else if (push && fill_after_pop == '0)
            head_n = sr;
        else
            head_n = mem[rd_next];
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= sr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            out_data  <= '0;
            last_word <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr   <= rd_next;
            fill     <= fill_n;
            out_data <= head_n;
            if (accept) last_word <= sr;
            overflow  <= ovf_set  | (overflow  & ~clr_flags);
            frame_err <= ferr_set | (frame_err & ~clr_flags);
        end
    end

    assign out_valid = (fill != '0);

endmodule

// File: tb/tb_serial_word_rx.sv
// Scoreboard bench for serial_word_rx: MSB-first instance fully checked,
// an LSB-first instance shares the line and is checked on a bit-reversed stream.
module tb_serial_word_rx;

    logic        clock = 0;
    logic        reset;
    logic        data_in, com_en, out_ready, clr_flags, out_ready_l;
    logic [31:0] out_data, last_word, out_data_l, last_word_l;
    logic        out_valid, overflow, frame_err, out_valid_l, overflow_l, frame_err_l;
    logic [2:0]  fill, fill_l;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_last;
    logic        exp_ovf, exp_ferr;

    always #5 clock = ~clock;

    serial_word_rx u_msb (
        .clock(clock), .reset(reset), .data_in(data_in), .com_en(com_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .last_word(last_word), .fill(fill), .overflow(overflow),
        .frame_err(frame_err), .clr_flags(clr_flags)
    );

    serial_word_rx #(.MSB_FIRST(0)) u_lsb (
        .clock(clock), .reset(reset), .data_in(data_in), .com_en(com_en),
        .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready_l),
        .last_word(last_word_l), .fill(fill_l), .overflow(overflow_l),
        .frame_err(frame_err_l), .clr_flags(clr_flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bitrev(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[31-i];
        return r;
    endfunction

    task automatic send_bits(input logic [31:0] w, input int nbits, input bit msb);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            com_en  = 1'b1;
            data_in = msb ? w[31-i] : w[i];
        end
    endtask

    // Lowers com_en after a full word and updates the model at the commit edge.
    task automatic finish_word(input logic [31:0] w, input bit pop_commit, input bit lat_chk);
        @(negedge clock);
        com_en  = 1'b0;
        data_in = 1'b0;
        @(negedge clock);
        @(negedge clock);
        if (lat_chk) chk("valid_before_latency", out_valid, 1'b0);
        if (pop_commit) begin
            chk("pop_on_commit_data", out_data, exp_q.pop_front());
            out_ready = 1'b1;
        end
        if (w != 32'hFFFF_FFFF) begin
            exp_last = w;
            if (exp_q.size() < 4) exp_q.push_back(w);
            else exp_ovf = 1'b1;
        end
        @(negedge clock);
        out_ready = 1'b0;
        if (lat_chk) chk("valid_at_latency", out_valid, 1'b1);
        repeat (2) @(negedge clock);
    endtask

    task automatic send_word(input logic [31:0] w, input bit pop_commit);
        send_bits(w, 32, 1'b1);
        finish_word(w, pop_commit, 1'b0);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_fill"}, {29'd0, fill}, exp_q.size());
        chk({tag, "_last"}, last_word, exp_last);
        chk({tag, "_ovf"}, overflow, exp_ovf);
        chk({tag, "_ferr"}, frame_err, exp_ferr);
    endtask

    task automatic drain();
        int guard = 0;
        while (guard < 16) begin
            @(negedge clock);
            out_ready = 1'b0;
            if (exp_q.size() == 0) break;
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_data", out_data, exp_q.pop_front());
            out_ready = 1'b1;
            guard++;
        end
        out_ready = 1'b0;
        chk("drain_empty_fill", {29'd0, fill}, 32'd0);
        chk("drain_empty_valid", out_valid, 1'b0);
        chk("drain_empty_data", out_data, 32'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clock);
        clr_flags = 1'b1;
        @(negedge clock);
        clr_flags = 1'b0;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        exp_last = '0;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; data_in = 1'b0; com_en = 1'b1;
        out_ready = 1'b0; out_ready_l = 1'b0; clr_flags = 1'b0;
        exp_last = '0; exp_ovf = 1'b0; exp_ferr = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 32'd0);
        chk_state("rst");
        com_en = 1'b0;
        repeat (4) @(negedge clock);

        // single word with latency check
        send_bits(32'h1200_0003, 32, 1'b1);
        finish_word(32'h1200_0003, 1'b0, 1'b1);
        chk("single_head", out_data, 32'h1200_0003);
        chk_state("single");
        drain();

        // idle filter
        send_word(32'hFFFF_FFFF, 1'b0);
        chk_state("idle_only");
        send_word(32'h0000_00A5, 1'b0);
        chk_state("idle_then_a5");
        drain();

        // overflow
        for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + 32'(i) * 32'h0101_0101, 1'b0);
        chk_state("overflow");
        pulse_clr();
        chk("ovf_cleared", overflow, 1'b0);
        drain();

        // framing error
        send_word(32'h0BAD_F00D, 1'b0);
        send_bits(32'h5555_AAAA, 17, 1'b1);
        @(negedge clock);
        com_en = 1'b0;
        exp_ferr = 1'b1;
        repeat (6) @(negedge clock);
        chk_state("frame_err");
        send_word(32'hCAFE_0001, 1'b0);
        chk_state("after_ferr");
        pulse_clr();
        chk("ferr_cleared", frame_err, 1'b0);
        drain();

        // full plus simultaneous pop
        for (int i = 0; i < 4; i++) send_word(32'hA000_0000 + 32'(i), 1'b0);
        chk_state("full");
        send_word(32'hB000_0005, 1'b1);
        chk_state("full_pop");
        drain();

        // reset mid-frame with com_en held high
        send_bits(32'h3C3C_1234, 10, 1'b1);
        do_reset();
        send_bits(32'h7777_0F0F, 12, 1'b1);
        @(negedge clock);
        com_en = 1'b0;
        repeat (6) @(negedge clock);
        chk_state("rst_mid");
        chk("rst_mid_valid", out_valid, 1'b0);
        send_word(32'h0101_8000, 1'b0);
        chk_state("after_rst_mid");
        drain();

        // LSB-first instance with a bit-reversed stream
        do_reset();
        com_en = 1'b0;
        repeat (4) @(negedge clock);
        send_bits(32'h1200_0003, 32, 1'b0);
        finish_word(bitrev(32'h1200_0003), 1'b0, 1'b0);
        chk("lsb_valid", out_valid_l, 1'b1);
        chk("lsb_data", out_data_l, 32'h1200_0003);
        chk("lsb_last", last_word_l, 32'h1200_0003);
        chk("lsb_fill", {29'd0, fill_l}, 32'd1);
        chk("lsb_flags", {30'd0, overflow_l, frame_err_l}, 32'd0);
        chk_state("msb_rev");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
